matrix_permute_engine: RTL

MATRIX_PERMUTE_ENGINE -- requirements
Module: matrix_permute_engine

---
 rtl/matrix_pkg.sv | 31 +++
 rtl/matrix_permute_round.sv | 45 ++++
 rtl/matrix_permute_engine.sv | 114 +++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: definitions shared by the matrix permute engine, its round
// sub-module and the bench.
//   MATRIX_DIM, CELLS : geometry of the 5x5 cell matrix
//   state_t           : engine FSM state encoding
//   cell_dest()       : destination cell index of one forward round
package matrix_pkg;

  localparam int MATRIX_DIM = 5;
  localparam int CELLS      = MATRIX_DIM * MATRIX_DIM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Cell i sits at x=i%5, y=i/5. It is first offset by (3,3). The offset
  // coordinates are then mapped to (y'+2, 2x'+3y'+2) mod 5. That linear map
  // has a non-zero determinant mod 5, so every round is a bijection.
  function automatic int cell_dest(input int i);
    int x, y, xs, ys, nx, ny;
    x  = i % MATRIX_DIM;
    y  = i / MATRIX_DIM;
    xs = (x + 3) % MATRIX_DIM;
    ys = (y + 3) % MATRIX_DIM;
    nx = (ys + 2) % MATRIX_DIM;
    ny = (((2 * xs + 3 * ys) % MATRIX_DIM) + 2) % MATRIX_DIM;
    return MATRIX_DIM * ny + nx;
  endfunction

endpackage

// File: rtl/matrix_permute_round.sv
// matrix_permute_round: one combinational permutation round over 25 lanes.
//   data   : input matrix, cell i at [i*LANE_W +: LANE_W]
//   inv    : 1 selects the inverse round (only used when
//            MATRIX_PERMUTE_INVERSE_EN is defined, otherwise ignored)
//   result : permuted matrix; whole lanes are moved, never split
// Optional feature macro: MATRIX_PERMUTE_INVERSE_EN
module matrix_permute_round
  import matrix_pkg::*;
#(
  parameter int LANE_W = 1
) (
  input  logic [CELLS*LANE_W-1:0] data,
  input  logic                    inv,
  output logic [CELLS*LANE_W-1:0] result
);

  logic [CELLS*LANE_W-1:0] fwd;

  // Pure wiring: each lane goes to a compile-time destination slot.
  generate
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_fwd
      localparam int DST = cell_dest(gi);
      assign fwd[DST*LANE_W +: LANE_W] = data[gi*LANE_W +: LANE_W];
    end
  endgenerate

`ifdef MATRIX_PERMUTE_INVERSE_EN
  logic [CELLS*LANE_W-1:0] bwd;

  // Inverse gathers from the forward destination instead of scattering to it.
  generate
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_inv
      localparam int DST = cell_dest(gi);
      assign bwd[gi*LANE_W +: LANE_W] = data[DST*LANE_W +: LANE_W];
    end
  endgenerate

  assign result = inv ? bwd : fwd;
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign result     = fwd;
`endif

endmodule

// File: rtl/matrix_permute_engine.sv
// matrix_permute_engine: applies in_rounds permutation rounds, one per clock,
// to a latched 5x5 matrix and holds the result until it is consumed.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (ready only in IDLE, not in reset)
//   in_data, in_rounds  : matrix and number of rounds, latched on accept
//   in_inv              : inverse-round select (MATRIX_PERMUTE_INVERSE_EN only)
//   out_valid/out_ready : result handshake, valid in DONE
//   out_data            : result, forced to 0 outside DONE
//   busy                : FSM is not IDLE
// Optional feature macro: MATRIX_PERMUTE_INVERSE_EN
module matrix_permute_engine
  import matrix_pkg::*;
#(
  parameter int LANE_W   = 1,
  parameter int ROUNDS_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CELLS*LANE_W-1:0] in_data,
  input  logic [ROUNDS_W-1:0]     in_rounds,
  input  logic                    in_inv,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CELLS*LANE_W-1:0] out_data,
  output logic                    busy
);

  state_t                  state_reg, state_next;
  logic [CELLS*LANE_W-1:0] data_reg, data_next;
  logic [ROUNDS_W-1:0]     cnt_reg, cnt_next;
  logic [CELLS*LANE_W-1:0] round_data;
  logic                    round_inv;

`ifdef MATRIX_PERMUTE_INVERSE_EN
  logic inv_reg, inv_next;
  assign round_inv = inv_reg;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign round_inv     = 1'b0;
`endif

  matrix_permute_round #(
    .LANE_W (LANE_W)
  ) u_round (
    .data   (data_reg),
    .inv    (round_inv),
    .result (round_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      cnt_reg   <= '0;
`ifdef MATRIX_PERMUTE_INVERSE_EN
      inv_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
`ifdef MATRIX_PERMUTE_INVERSE_EN
      inv_reg   <= inv_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
`ifdef MATRIX_PERMUTE_INVERSE_EN
    inv_next   = inv_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          data_next  = in_data;
          cnt_next   = in_rounds;
`ifdef MATRIX_PERMUTE_INVERSE_EN
          inv_next   = in_inv;
`endif
          state_next = (in_rounds != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // The counter only counts down to 1 here, so the maximum round count
        // never wraps.
        data_next = round_data;
        cnt_next  = cnt_reg - ROUNDS_W'(1);
        if (cnt_reg == ROUNDS_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are also gated by rst so they read 0 in the reset cycle itself,
  // before the synchronous reset has taken effect on the state register.
  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE) && !rst;
  assign busy      = (state_reg != IDLE) && !rst;
  assign out_data  = out_valid ? data_reg : '0;

endmodule
